// File: rtl/cons_fetch_if.sv
// Bundle between cons_fetch, its evaluator-side requester and the cell memory read port.
// start is level-sampled only while busy is low; done pulses one cycle with err/car/cdr valid and held.
interface cons_fetch_if #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 16
);
   logic                 start;
   logic [DataWidth-1:0] ptr;
   logic                 busy;
   logic                 done;
   logic [1:0]           err;
   logic [DataWidth-1:0] car;
   logic [DataWidth-1:0] cdr;
   logic                 mem_req;
   logic [AddrWidth-1:0] mem_addr;
   logic                 mem_ready;
   logic [DataWidth-1:0] mem_data;

   modport master (
      output start, ptr, mem_ready, mem_data,
      input  busy, done, err, car, cdr, mem_req, mem_addr
   );

   modport slave (
      input  start, ptr, mem_ready, mem_data,
      output busy, done, err, car, cdr, mem_req, mem_addr
   );
endinterface

// File: rtl/cons_fetch.sv
// Fetches car (addr) and cdr (addr-1) of a cons cell through the memory read port.
// Every output is registered; the FSM state is visible on dbg_state.
module cons_fetch #(
   parameter int AddrWidth     = 12,
   parameter int DataWidth     = 16,
   parameter int TimeoutCycles = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   cons_fetch_if.slave  bus,
   output logic [2:0]   dbg_state
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] REQ_CAR  = 3'd1;
   localparam logic [2:0] WAIT_CAR = 3'd2;
   localparam logic [2:0] REQ_CDR  = 3'd3;
   localparam logic [2:0] WAIT_CDR = 3'd4;
   localparam logic [2:0] FINISH   = 3'd5;

   localparam logic [1:0] ErrOk      = 2'b00;
   localparam logic [1:0] ErrNotCons = 2'b01;
   localparam logic [1:0] ErrTimeout = 2'b10;
   localparam logic [1:0] ErrUnder   = 2'b11;

   localparam int HdrWidth = DataWidth - AddrWidth;
   // Header is {1'b0, tag}; a set top bit is not a valid pointer, so it is rejected with the tag.
   localparam logic [HdrWidth-1:0] ConsHdr = HdrWidth'(3'b001);

   localparam int CntWidth = $clog2(TimeoutCycles + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
   localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
   localparam logic [AddrWidth-1:0] AddrZero = '0;

   logic [2:0]           state;
   logic [CntWidth-1:0]  cnt;
   logic [AddrWidth-1:0] addr_q;
   logic [HdrWidth-1:0]  hdr;
   logic [AddrWidth-1:0] addr;

   assign hdr       = bus.ptr[DataWidth-1:AddrWidth];
   assign addr      = bus.ptr[AddrWidth-1:0];
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= ErrOk;
         bus.car      <= '0;
         bus.cdr      <= '0;
         bus.mem_req  <= 1'b0;
         bus.mem_addr <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  if (hdr != ConsHdr) begin
                     bus.err  <= ErrNotCons;
                     bus.done <= 1'b1;
                     state    <= FINISH;
                  end else if (addr == AddrZero) begin
                     // cdr would live at address -1, so refuse before touching memory
                     bus.err  <= ErrUnder;
                     bus.done <= 1'b1;
                     state    <= FINISH;
                  end else begin
                     addr_q       <= addr;
                     bus.mem_addr <= addr;
                     bus.mem_req  <= 1'b1;
                     bus.err      <= ErrOk;
                     state        <= REQ_CAR;
                  end
               end
            end
            REQ_CAR: begin
               bus.mem_req <= 1'b0;
               cnt         <= '0;
               state       <= WAIT_CAR;
            end
            WAIT_CAR: begin
               if (bus.mem_ready) begin
                  bus.car      <= bus.mem_data;
                  bus.mem_addr <= addr_q - AddrOne;
                  bus.mem_req  <= 1'b1;
                  state        <= REQ_CDR;
               end else if (cnt == CntLast) begin
                  bus.err  <= ErrTimeout;
                  bus.done <= 1'b1;
                  state    <= FINISH;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            REQ_CDR: begin
               bus.mem_req <= 1'b0;
               cnt         <= '0;
               state       <= WAIT_CDR;
            end
            WAIT_CDR: begin
               if (bus.mem_ready) begin
                  bus.cdr  <= bus.mem_data;
                  bus.err  <= ErrOk;
                  bus.done <= 1'b1;
                  state    <= FINISH;
               end else if (cnt == CntLast) begin
                  bus.err  <= ErrTimeout;
                  bus.done <= 1'b1;
                  state    <= FINISH;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            FINISH: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy    <= 1'b0;
               bus.mem_req <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cons_fetch.sv
// Directed bench for cons_fetch against a one-cycle-latency cell memory model.
module tb_cons_fetch;
   logic        clk;
   logic        rst_n;
   logic [2:0]  dbg_state;
   logic        mem_on;
   logic [15:0] mem [0:4095];
   int          req_count;
   logic [11:0] addr_log[$];
   int          checks;
   int          passes;

   cons_fetch_if #(.AddrWidth(12), .DataWidth(16)) bus ();

   cons_fetch #(.AddrWidth(12), .DataWidth(16), .TimeoutCycles(15)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: answers a req with data_ready one cycle later when enabled
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.mem_ready <= 1'b0;
         bus.mem_data  <= '0;
      end else begin
         bus.mem_ready <= bus.mem_req && mem_on;
         bus.mem_data  <= mem[bus.mem_addr];
      end
   end

   always @(posedge clk) begin
      if (bus.mem_req) begin
         req_count = req_count + 1;
         addr_log.push_back(bus.mem_addr);
      end
   end

   task automatic do_fetch(input logic [15:0] p, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.ptr   = p;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.mem_req, bus.err} !== 5'b0 || bus.car !== 16'h0 ||
          bus.cdr !== 16'h0 || bus.mem_addr !== 12'h0 || dbg_state !== 3'd0)
         $display("FAIL reset: busy=%b done=%b req=%b err=%b car=%h cdr=%h addr=%h st=%0d want all 0",
                  bus.busy, bus.done, bus.mem_req, bus.err, bus.car, bus.cdr, bus.mem_addr, dbg_state);
      else passes++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_fetch;
      int lat;
      req_count = 0;
      addr_log.delete();
      do_fetch(16'h1004, lat);
      checks++;
      if (lat !== 5) $display("FAIL basic_latency: got %0d want 5", lat); else passes++;
      checks++;
      if (bus.car !== 16'h0002 || bus.cdr !== 16'h0001)
         $display("FAIL basic_data: car=%h cdr=%h want 0002 0001", bus.car, bus.cdr);
      else passes++;
      checks++;
      if (bus.err !== 2'b00) $display("FAIL basic_err: got %b want 00", bus.err); else passes++;
      checks++;
      if (addr_log.size() !== 2 || addr_log[0] !== 12'h004 || addr_log[1] !== 12'h003)
         $display("FAIL basic_addrs: n=%0d want 2 reqs at 004 then 003", addr_log.size());
      else passes++;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
         $display("FAIL basic_after: done=%b busy=%b want 0 0", bus.done, bus.busy);
      else passes++;
   endtask

   task automatic test_not_cons;
      int lat;
      req_count = 0;
      do_fetch(16'h0001, lat);
      checks++;
      if (lat !== 1 || bus.err !== 2'b01)
         $display("FAIL not_cons: lat=%0d err=%b want 1 01", lat, bus.err);
      else passes++;
      checks++;
      if (req_count !== 0 || bus.car !== 16'h0002 || bus.cdr !== 16'h0001)
         $display("FAIL not_cons_side: reqs=%0d car=%h cdr=%h want 0 0002 0001", req_count, bus.car, bus.cdr);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_underflow;
      int lat;
      req_count = 0;
      do_fetch(16'h1000, lat);
      checks++;
      if (lat !== 1 || bus.err !== 2'b11 || req_count !== 0)
         $display("FAIL underflow: lat=%0d err=%b reqs=%0d want 1 11 0", lat, bus.err, req_count);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int lat;
      mem_on = 1'b0;
      do_fetch(16'h1004, lat);
      checks++;
      if (lat !== 17 || bus.err !== 2'b10)
         $display("FAIL timeout: lat=%0d err=%b want 17 10", lat, bus.err);
      else passes++;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) $display("FAIL timeout_busy: got %b want 0", bus.busy); else passes++;
      mem_on = 1'b1;
   endtask

   task automatic test_cons_written;
      int lat;
      mem[6] = 16'hAAAA;
      mem[5] = 16'h5555;
      do_fetch(16'h1006, lat);
      checks++;
      if (lat !== 5 || bus.car !== 16'hAAAA || bus.cdr !== 16'h5555 || bus.err !== 2'b00)
         $display("FAIL cons_written: lat=%0d car=%h cdr=%h err=%b want 5 AAAA 5555 00",
                  lat, bus.car, bus.cdr, bus.err);
      else passes++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int dones;
      dones = 0;
      req_count = 0;
      bus.ptr   = 16'h1004;
      bus.start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (bus.done) dones++;
         if (n == 12) bus.start = 1'b0;
      end
      checks++;
      if (dones !== 2 || req_count !== 4)
         $display("FAIL back_to_back: dones=%0d reqs=%0d want 2 4", dones, req_count);
      else passes++;
   endtask

   task automatic test_reset_mid;
      int dones;
      dones = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.ptr   = 16'h1006;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (dbg_state !== 3'd4) $display("FAIL mid_state: got %0d want 4", dbg_state); else passes++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.car !== 16'h0)
         $display("FAIL mid_reset: req=%b busy=%b done=%b car=%h want 0 0 0 0000",
                  bus.mem_req, bus.busy, bus.done, bus.car);
      else passes++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checks++;
      if (dones !== 0) $display("FAIL mid_no_done: dones=%0d want 0", dones); else passes++;
   endtask

   initial begin
      checks    = 0;
      passes    = 0;
      req_count = 0;
      mem_on    = 1'b1;
      bus.start = 1'b0;
      bus.ptr   = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
      mem[4] = 16'h0002;
      mem[3] = 16'h0001;
      test_reset();
      test_basic_fetch();
      test_not_cons();
      test_underflow();
      test_timeout();
      test_cons_written();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
